branch_predict_unit: RTL

Parametrised branch unit for the pipelined MIPS core: a PC-indexed table of 2-bit saturating counters that supplies a taken/not-taken prediction at fetch, and a resolver that evaluates the branch condition later in the pipeline. From the resolved outcome it computes the redirect PC, raises a mispredict flush, trains the table and counts branches and mispredictions. It replaces the purely combinational branch comparator. It sits between the F-stage PC logic and the D-stage comparator and forwarding outputs.

---
 rtl/branch_pkg.sv | 30 +++
 rtl/branch_hist_table.sv | 40 ++++
 rtl/branch_predict_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch predictor: condition codes, 2-bit counter
// states and the saturating counter update used by the history table.
package branch_pkg;

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BGEZ = 4'd3;
    localparam logic [3:0] BR_BLTZ = 4'd4;
    localparam logic [3:0] BR_BGTZ = 4'd5;
    localparam logic [3:0] BR_BLEZ = 4'd6;

    localparam logic [1:0] CNT_SNT   = 2'd0;
    localparam logic [1:0] CNT_WNT   = 2'd1;
    localparam logic [1:0] CNT_WT    = 2'd2;
    localparam logic [1:0] CNT_ST    = 2'd3;
    localparam logic [1:0] CNT_RESET = CNT_WNT;

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != CNT_ST) begin
            nxt = cnt + 2'd1;
        end else if (!taken && cnt != CNT_SNT) begin
            nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_hist_table.sv
// Table of 2-bit saturating counters with one asynchronous read port and one
// synchronous write port; reads never see a same-cycle write.
module branch_hist_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] cnt_d [ENTRIES];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_idx] = cnt_next(cnt_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_RESET;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit: fetch-time prediction from the history table, late resolution
// of the branch condition, redirect/flush generation and branch statistics.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ENTRIES = 64,
    parameter int IDX_LSB = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic              stall,
    input  logic [DATA_W-1:0] res_pc,
    input  logic [DATA_W-1:0] res_target,
    input  logic              res_pred,
    input  logic [3:0]        branch_op,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              res_taken,
    output logic              mispredict,
    output logic [DATA_W-1:0] redirect_pc,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]        pred_cnt;
    logic              cond_true;
    logic              op_valid;
    logic              effective;
    logic              rs_neg;
    logic              rs_zero;
    logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic              pc_bits_unused;

    // Only the index slice of each PC reaches the table.
    assign pc_bits_unused = ^pred_pc;

    branch_hist_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (pred_pc[IDX_LSB +: IDX_W]),
        .rd_cnt   (pred_cnt),
        .wr_en    (effective),
        .wr_idx   (res_pc[IDX_LSB +: IDX_W]),
        .wr_taken (res_taken)
    );

    assign pred_taken = pred_cnt[1];
    assign rs_neg     = rs[DATA_W-1];
    assign rs_zero    = (rs == '0);

    always_comb begin
        cond_true = 1'b0;
        op_valid  = 1'b1;
        case (branch_op)
            BR_BEQ:  cond_true = (rs == rt);
            BR_BNE:  cond_true = (rs != rt);
            BR_BGEZ: cond_true = !rs_neg;
            BR_BLTZ: cond_true = rs_neg;
            BR_BGTZ: cond_true = !rs_neg && !rs_zero;
            BR_BLEZ: cond_true = rs_neg || rs_zero;
            default: op_valid  = 1'b0;
        endcase
    end

    assign res_taken   = cond_true && op_valid;
    assign effective   = res_valid && !stall && op_valid;
    assign mispredict  = effective && (res_taken != res_pred);
    // Not-taken resumes after the delay slot.
    assign redirect_pc = !res_valid ? '0 :
                         res_taken  ? res_target : res_pc + DATA_W'(8);

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (stat_clr) begin
            branch_cnt_d  = '0;
            mispred_cnt_d = '0;
        end else begin
            if (effective && branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + STAT_W'(1);
            end
            if (mispredict && mispred_cnt_q != '1) begin
                mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
